// File: rtl/dmem_responder.sv
// dmem_responder: target end of the MEM stage load/store interface.
// Accepts one word access at a time, waits LATENCY cycles, then commits the
// store or returns the load data alongside a one-cycle rsp_valid pulse.
// stall holds the pipeline while a request is pending and not yet answered.

module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Counter start value; LATENCY is limited to 1..15 so four bits suffice.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 32'sd1);
    localparam bit         LAT_ONE  = (LATENCY == 32'sd1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic [15:0]         rdata_q;

    // Access performed on the edge that enters RESP.
    logic                access_s;
    logic                acc_we_s;
    logic [ADDR_W-1:0]   acc_addr_s;
    logic [15:0]         acc_wdata_s;
    logic                mem_we_s;
    logic                rd_en_s;

    // Upper address bits alias onto the implemented range.
    logic                addr_hi_unused_s;

    logic [15:0]         mem [2**ADDR_W];

    assign addr_hi_unused_s = ^req_addr[15:ADDR_W];

    // Next-state, counter and request-latch logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        access_s    = 1'b0;
        acc_we_s    = we_q;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[ADDR_W-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    if (LAT_ONE) begin
                        // Zero wait: the access uses the live request directly.
                        state_d     = ST_RESP;
                        access_s    = 1'b1;
                        acc_we_s    = req_we;
                        acc_addr_s  = req_addr[ADDR_W-1:0];
                        acc_wdata_s = req_wdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The edge that takes the counter to zero enters RESP.
                if (cnt_q <= 4'd1) begin
                    cnt_d    = 4'd0;
                    state_d  = ST_RESP;
                    access_s = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Store and load enables; no array write can happen while reset is held.
    always_comb begin
        mem_we_s = 1'b0;
        rd_en_s  = 1'b0;
        if (access_s && !rst) begin
            mem_we_s = acc_we_s;
            rd_en_s  = ~acc_we_s;
        end else begin
            mem_we_s = 1'b0;
            rd_en_s  = 1'b0;
        end
    end

    // FSM state, wait counter and latched request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Load data register; updated only by a load entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 16'h0000;
        end else if (rd_en_s) begin
            rdata_q <= mem[acc_addr_s];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    // Word array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[acc_addr_s] <= acc_wdata_s;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign stall     = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses LATENCY=3, instance 1 LATENCY=1.
// Drivers push expected responses into per-instance queues; a monitor pops
// and compares each time rsp_valid is seen.

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv   [2];
    logic        rw   [2];
    logic [15:0] ra   [2];
    logic [15:0] rd   [2];
    logic        rdy  [2];
    logic        vld  [2];
    logic [15:0] rdat [2];
    logic        stl  [2];

    typedef struct {
        logic        we;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_we(rw[0]), .req_addr(ra[0]), .req_wdata(rd[0]),
        .req_ready(rdy[0]), .rsp_valid(vld[0]), .rsp_rdata(rdat[0]), .stall(stl[0])
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_we(rw[1]), .req_addr(ra[1]), .req_wdata(rd[1]),
        .req_ready(rdy[1]), .rsp_valid(vld[1]), .rsp_rdata(rdat[1]), .stall(stl[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Issue one request on instance s and wait for its response pulse.
    task automatic issue(input int s, input logic we, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] ex,
                         input logic chg = 1'b0, input logic [15:0] a2 = 16'h0,
                         input logic [15:0] d2 = 16'h0);
        int   n;
        int   sc;
        int   lat;
        exp_t e;
        lat = (s == 0) ? 3 : 1;
        n = 0;
        while (rdy[s] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rdy[s] !== 1'b1) begin
            fail("ready_wait");
            return;
        end
        e.we    = we;
        e.rdata = ex;
        e.cyc   = cyc + lat;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
        rw[s] = we;
        ra[s] = a;
        rd[s] = d;
        rv[s] = 1'b1;
        #1;
        sc = (stl[s] === 1'b1) ? 1 : 0;
        @(negedge clk);
        chk($sformatf("ready_drop%0d", s), {31'd0, rdy[s]}, 32'd0);
        if (chg) begin
            ra[s] = a2;
            rd[s] = d2;
        end
        n = 1;
        while (vld[s] !== 1'b1 && n < 40) begin
            if (stl[s] === 1'b1) sc++;
            @(negedge clk);
            n++;
        end
        if (vld[s] !== 1'b1) begin
            fail($sformatf("rsp_wait%0d", s));
        end else begin
            chk($sformatf("stall_in_rsp%0d", s), {31'd0, stl[s]}, 32'd0);
            chk($sformatf("stall_cycles%0d", s), sc, lat);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (vld[s] === 1'b1) begin
                if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp%0d: got rsp_valid 1 expected 0", s);
                end else begin
                    if (s == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("rsp_cycle%0d", s), cyc, e.cyc);
                    chk($sformatf("rsp_rdata%0d we=%0b", s, e.we), {16'd0, rdat[s]}, {16'd0, e.rdata});
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rv[s] = 1'b0;
            rw[s] = 1'b0;
            ra[s] = 16'h0;
            rd[s] = 16'h0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_ready", {31'd0, rdy[s]}, 32'd1);
            chk("reset_valid", {31'd0, vld[s]}, 32'd0);
            chk("reset_rdata", {16'd0, rdat[s]}, 32'h0);
            chk("reset_stall", {31'd0, stl[s]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // LATENCY=3: store then load, rdata holds afterwards.
        issue(0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000);
        issue(0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF);
        rv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rdata_hold", {16'd0, rdat[0]}, 32'h0000BEEF);

        // Address aliasing on the upper bits.
        issue(0, 1'b1, 16'h0407, 16'h1234, 16'hBEEF);
        issue(0, 1'b0, 16'h0007, 16'h0000, 16'h1234);

        // Request changes during WAIT are ignored.
        issue(0, 1'b1, 16'h0011, 16'h7777, 16'h1234);
        issue(0, 1'b1, 16'h0010, 16'hAAAA, 16'h1234, 1'b1, 16'h0011, 16'h5A5A);
        issue(0, 1'b0, 16'h0010, 16'h0000, 16'hAAAA);
        issue(0, 1'b0, 16'h0011, 16'h0000, 16'h7777);
        issue(0, 1'b1, 16'h0020, 16'h0000, 16'h7777);
        rv[0] = 1'b0;
        @(negedge clk);

        // Reset during WAIT of a store: aborted, no response, outputs reset.
        chk("pre_abort_ready", {31'd0, rdy[0]}, 32'd1);
        rw[0] = 1'b1;
        ra[0] = 16'h0020;
        rd[0] = 16'h5555;
        rv[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, rdy[0]}, 32'd1);
        chk("abort_valid", {31'd0, vld[0]}, 32'd0);
        chk("abort_rdata", {16'd0, rdat[0]}, 32'h0);
        chk("abort_stall_hi", {31'd0, stl[0]}, 32'd1);
        rv[0] = 1'b0;
        #1;
        chk("abort_stall_lo", {31'd0, stl[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(0, 1'b0, 16'h0020, 16'h0000, 16'h0000);
        rv[0] = 1'b0;

        // LATENCY=1 back-to-back stream, one response every second cycle.
        issue(1, 1'b1, 16'h0003, 16'h1111, 16'h0000);
        issue(1, 1'b0, 16'h0003, 16'h0000, 16'h1111);
        issue(1, 1'b1, 16'h0003, 16'h2222, 16'h1111);
        issue(1, 1'b0, 16'h0003, 16'h0000, 16'h2222);
        issue(1, 1'b1, 16'h03FF, 16'h3333, 16'h2222);
        issue(1, 1'b0, 16'h03FF, 16'h0000, 16'h3333);
        rv[1] = 1'b0;

        repeat (4) @(negedge clk);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the WISC-S15 5-stage pipeline; it sits on the target end of the MEM stage's load/store request interface.
- The MEM stage issues one word read (LW) or write (SW) at a time.
- This block latches the request, waits a parameterized access latency, then commits the write or returns the read data with a one-cycle response pulse.
- It raises stall so the pipeline freezes while the access is outstanding.

Parameters:
- ADDR_W, 10, word-address bits implemented; the array holds 2**ADDR_W 16-bit words.
- LATENCY, 3, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  MEM stage has a load/store pending; held high until rsp_valid.
- req_we  input  1  1 = store (SW), 0 = load (LW).
- req_addr  input  16  word address (ALU result).
- req_wdata  input  16  store data.
- req_ready  output  1  responder idle and able to accept.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  16  load data, registered.
- stall  output  1  pipeline freeze request.

Behaviour:
- State machine with three states:
  - IDLE: req_ready=1.
  - WAIT: counting.
  - RESP: rsp_valid=1 for exactly one cycle.
- Acceptance:
  - At a rising edge in IDLE with req_valid=1, the block latches req_we, req_addr[ADDR_W-1:0] and req_wdata into internal registers.
  - Counter loads LATENCY-1.
  - Next state is RESP if LATENCY=1, else WAIT.
- WAIT: counter decrements each edge; on the edge where it reaches 0 the state moves to RESP.
- Latency: accepted at edge T → rsp_valid high during the cycle after edge T+LATENCY-1. With LATENCY=1, rsp_valid is high in the cycle immediately after acceptance.
- RESP, entered on an edge:
  - Load: array[addr] is registered into rsp_rdata on that same edge, so rsp_rdata is valid while rsp_valid=1.
  - Store: array[addr] is written on that same edge; rsp_rdata keeps its previous value.
  - Next edge returns the state to IDLE unconditionally.
- Back-to-back: a new request is accepted no earlier than the edge after the RESP cycle, because the requester keeps req_valid asserted only through RESP. Maximum throughput is one access per LATENCY+1 cycles.
- Request changes while in WAIT are ignored; the latched copy is used.
- Address: req_addr[15:ADDR_W] is ignored (aliasing/wrap); no error is reported.
- Read-after-write: a load issued after a store's RESP cycle returns the new value.
- stall = req_valid & ~rsp_valid, combinational.
  - Asserted from the first cycle req_valid is seen until the response cycle.
  - Deasserted in the RESP cycle so the pipeline advances on the following edge.
  - 0 when req_valid=0.
- req_ready = (state==IDLE).
- Reset (async, immediate on rst rising):
  - State = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 16'h0000, req_ready = 1.
  - Latched request registers are cleared.
  - stall then follows req_valid.
  - Array contents are NOT reset.
- Reset mid-operation: an outstanding access is aborted. A store whose RESP edge has not occurred is not committed and no rsp_valid is produced. After rst deasserts, a still-high req_valid is accepted at the next edge as a new request.
- rst while rsp_valid=1: rsp_valid drops immediately. A store committed on that RESP edge remains committed.

Test Plan:
- Reset, LATENCY=3, then store addr 0x0005 data 0xBEEF:
  - req_ready drops one cycle after req_valid is raised.
  - rsp_valid pulses exactly 3 cycles after the acceptance edge.
  - stall is high for 3 cycles and low in the rsp_valid cycle.
- Load 0x0005 right after that store completes → rsp_rdata=0xBEEF with rsp_valid, 3 cycles post-acceptance; rsp_rdata holds 0xBEEF afterwards.
- Aliasing, ADDR_W=10: store 0x0407 data 0x1234, then load 0x0007 → 0x1234.
- LATENCY=1, back-to-back load/store/load stream:
  - rsp_valid is seen every 2nd cycle.
  - req_ready toggles 1/0.
  - No request is dropped or duplicated (compare against a scoreboard model).
- Change req_addr/req_wdata mid-WAIT during a store to 0x0010 data 0xAAAA → the array holds 0xAAAA at 0x0010; the new address is untouched.
- Assert rst in WAIT of a store 0x0020 data 0x5555 (prior value 0x0000):
  - rsp_valid is never pulsed for it.
  - The outputs immediately show the reset values.
  - A later load of 0x0020 returns 0x0000.
